data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Shares the single-ported `Data_mem` between two requesters: port 0 is the CPU load/store unit and port 1 is the debug/DMA dump engine. It accepts one request at a time with a req/gnt handshake and drives `Data_mem`'s address, data, `we` and `re` inputs. It tracks the memory's synchronous read latency and returns read data to the requester that issued the read. Default arbitration between the two ports is round-robin.

## Interface
- ADDR_WIDTH, 32, address width passed to memory unchanged
- DATA_WIDTH, 32, data word width
- RD_LATENCY, 1, cycles from the `Mem_re` sampling edge to valid `Mem_data_out`; must be ≥1
- Clk  in  1  single clock; all state updates on rising edge
- Rst_n  in  1  reset, asynchronous and active-low
- Req_0 / Req_1  in  1  request; held until matching Gnt
- We_0 / We_1  in  1  1 = write, 0 = read
- Addr_0 / Addr_1  in  ADDR_WIDTH  request address
- Wdata_0 / Wdata_1  in  DATA_WIDTH  write data
- Gnt_0 / Gnt_1  out  1  one-cycle pulse: command issued to memory this cycle
- Rvalid_0 / Rvalid_1  out  1  one-cycle pulse: Rdata valid
- Rdata_0 / Rdata_1  out  DATA_WIDTH  registered read data; held until the next read return on that port
- Mem_address  out  ADDR_WIDTH  to Data_mem address
- Mem_data_in  out  DATA_WIDTH  to Data_mem data in
- Mem_we / Mem_re  out  1  to Data_mem write/read enables
- Mem_data_out  in  DATA_WIDTH  from Data_mem

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any Req is high, the arbiter picks a winner and latches its We, Addr and Wdata.
  - Next state is ISSUE. Otherwise the block stays in IDLE.
- ISSUE (1 cycle):
  - Mem_re or Mem_we is driven high per the latched We, with the latched address and data.
  - Gnt of the winner is high.
  - Next state is IDLE for a write, WAIT for a read.
- WAIT (RD_LATENCY cycles):
  - A down-counter loaded with RD_LATENCY runs; its width is $clog2(RD_LATENCY+1).
  - On the edge ending the last WAIT cycle, Mem_data_out is captured into the owner's Rdata and that port's Rvalid is set for one cycle.
  - Next state is IDLE.
- Arbitration is round-robin. The last-granted pointer updates at ISSUE. The pointer resets to 1, so port 0 wins the first tie.
- Mem_we and Mem_re are never high together and are both 0 outside ISSUE. Mem_address and Mem_data_in hold their last values.
- Once a winner is latched, the command issues even if its Req drops; that is a protocol violation, but the behaviour is defined. Req is sampled only in IDLE.
- Reset values: all Gnt, Rvalid, Mem_we and Mem_re are 0. Rdata, Mem_address and Mem_data_in are 0. State is IDLE, pointer is 1.
- Reset asserted mid-read: the transaction is dropped, no Rvalid is ever produced, and the memory contents are not touched by the arbiter.

## Timing
- Req seen in IDLE at cycle N, then Gnt and Mem_we/Mem_re high in cycle N+1.
- Read data: Rvalid high in cycle N+2+RD_LATENCY.
- Rvalid coincides with the IDLE cycle, so a new arbitration may occur in the same cycle.
- Throughput: one write per 2 cycles; one read per 2+RD_LATENCY cycles.
- A requester may deassert Req in the cycle after Gnt. If Req is still high in the following IDLE cycle, it is treated as a new request.

## Configuration
- DATA_MEM_ARB_PRIO_EN
  - Defined: fixed priority, port 0 always wins. The pointer logic is removed.
  - Undefined: round-robin as described above.

## Structure
- data_mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT)
  - port index constants PORT_CPU=0 and PORT_DBG=1
  - default width constants
- Sub-module rr_arbiter_2 holds the two-requester pick and pointer register. The priority variant is selected inside it by the macro.

## Test plan
- Reset release with no requests: all outputs stay 0 for 5 cycles and Mem_we/Mem_re never pulse.
- Port 0 write, Addr=1024, Wdata=32'hFFFFFFFF:
  - Gnt_0 and Mem_we high exactly one cycle later, with Mem_address=1024.
  - A following port 0 read of 1024 returns Rdata_0=32'hFFFFFFFF, with Rvalid_0 at issue+1+RD_LATENCY.
- Req_0 and Req_1 both held high for reads of 1024 and 1028:
  - Grants alternate 0,1,0,1.
  - Each Rvalid pulses only on its own port with the correct data.
  - With DATA_MEM_ARB_PRIO_EN defined, port 1 is never granted while Req_0 stays high.
- Port 1 read issued, Req_0 raised during WAIT: Gnt_0 is delayed until after Rvalid_1, and Rdata_1 is unaffected.
- Rst_n pulled low during WAIT of a read:
  - All outputs are 0 asynchronously and no Rvalid appears.
  - After release, a fresh read of 1024 completes normally.
- Regression repeated with RD_LATENCY=3: Rvalid arrives 5 cycles after the Req is first seen in IDLE.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the Data_mem arbiter.
// State encoding, port indices and default widths.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_RD_LAT = 1;

  // Width of a down-counter that must hold the value lat.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// Two-requester pick with last-granted pointer (round-robin).
// DATA_MEM_ARB_PRIO_EN selects fixed priority with port 0 winning.
module rr_arbiter_2
  import data_mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       win_o
);

`ifdef DATA_MEM_ARB_PRIO_EN

  logic unused_prio;
  assign unused_prio = ^{clk_i, rst_ni, upd_i, upd_idx_i, req_i[1]};

  // port 0 wins whenever it asks
  always_comb begin
    win_o = req_i[PORT_CPU] ? PORT_CPU : PORT_DBG;
  end

`else

  logic last_q;
  logic last_d;

  // remember which port was issued most recently
  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = upd_idx_i;
  end

  // pointer register, starts on port 1 so port 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= PORT_DBG;
    else         last_q <= last_d;
  end

  // on a tie the port that was not served last goes next
  always_comb begin
    win_o = PORT_CPU;
    unique case (req_i)
      2'b11:   win_o = ~last_q;
      2'b10:   win_o = PORT_DBG;
      default: win_o = PORT_CPU;
    endcase
  end

`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares single-ported Data_mem between CPU (port 0) and DBG (port 1).
// Define DATA_MEM_ARB_PRIO_EN for fixed priority instead of round-robin.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_W,
  parameter int unsigned DATA_WIDTH = DEF_DATA_W,
  parameter int unsigned RD_LATENCY = DEF_RD_LAT
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Req_0,
  input  logic                  Req_1,
  input  logic                  We_0,
  input  logic                  We_1,
  input  logic [ADDR_WIDTH-1:0] Addr_0,
  input  logic [ADDR_WIDTH-1:0] Addr_1,
  input  logic [DATA_WIDTH-1:0] Wdata_0,
  input  logic [DATA_WIDTH-1:0] Wdata_1,
  output logic                  Gnt_0,
  output logic                  Gnt_1,
  output logic                  Rvalid_0,
  output logic                  Rvalid_1,
  output logic [DATA_WIDTH-1:0] Rdata_0,
  output logic [DATA_WIDTH-1:0] Rdata_1,
  output logic [ADDR_WIDTH-1:0] Mem_address,
  output logic [DATA_WIDTH-1:0] Mem_data_in,
  output logic                  Mem_we,
  output logic                  Mem_re,
  input  logic [DATA_WIDTH-1:0] Mem_data_out
);

  localparam int unsigned CW = cnt_width(RD_LATENCY);

  state_e                state_q;
  logic                  owner_q;
  logic [CW-1:0]         cnt_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  rv0_q;
  logic                  rv1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mwe_q;
  logic                  mre_q;

  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter_2 u_arb (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .req_i     ({Req_1, Req_0}),
    .upd_i     (state_q == ISSUE),
    .upd_idx_i (owner_q),
    .win_o     (win)
  );

  // steer the winning port's command towards the latches
  always_comb begin
    sel_we    = We_0;
    sel_addr  = Addr_0;
    sel_wdata = Wdata_0;
    if (win == PORT_DBG) begin
      sel_we    = We_1;
      sel_addr  = Addr_1;
      sel_wdata = Wdata_1;
    end
  end

  // request/issue/wait sequencer with registered handshake and memory outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      owner_q  <= PORT_CPU;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mwe_q    <= 1'b0;
      mre_q    <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      mwe_q  <= 1'b0;
      mre_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Req_0 | Req_1) begin
            state_q <= ISSUE;
            owner_q <= win;
            gnt0_q  <= (win == PORT_CPU);
            gnt1_q  <= (win == PORT_DBG);
            mwe_q   <= sel_we;
            mre_q   <= ~sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
          end
        end
        ISSUE: begin
          if (mwe_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CW'(RD_LATENCY);
          end
        end
        WAIT: begin
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            if (owner_q == PORT_DBG) begin
              rdata1_q <= Mem_data_out;
              rv1_q    <= 1'b1;
            end else begin
              rdata0_q <= Mem_data_out;
              rv0_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Gnt_0       = gnt0_q;
  assign Gnt_1       = gnt1_q;
  assign Rvalid_0    = rv0_q;
  assign Rvalid_1    = rv1_q;
  assign Rdata_0     = rdata0_q;
  assign Rdata_1     = rdata1_q;
  assign Mem_address = addr_q;
  assign Mem_data_in = wdata_q;
  assign Mem_we      = mwe_q;
  assign Mem_re      = mre_q;

endmodule
